fx2_slave_fifo_writer: RTL and testbench

//  Sequences 8-bit ADC samples into the FX2LP slave-FIFO write port (IN endpoint).

---
 rtl/fx2_slave_fifo_writer.sv | 194 +++++++++++++++++++
 tb/tb_fx2_slave_fifo_writer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fx2_slave_fifo_writer.sv
// fx2_slave_fifo_writer
//   Streams decimated 8-bit ADC samples into the FX2LP slave-FIFO write port.
//   Samples are taken every max(DIV,1) clocks while streaming and queued in a
//   small FIFO. The queue drains to FD_OUT/SLWRN whenever the FX2 reports space.
//   Samples that arrive while the queue is full are dropped and counted.
//
// Optional feature macro: FX2_PKTEND_FLUSH_EN
//   defined   : after draining on ENABLE=0, a partial packet is committed with a
//               single-clock PKTENDN pulse.
//   undefined : no packet commit; PKTENDN is tied high.
//
// Ports
//   CLK          in   IFCLK, all logic on the rising edge
//   RESET_N      in   asynchronous active-low reset
//   ENABLE       in   1 = capture/stream, 0 = drain then idle
//   DIV          in   sample period in clocks (0 and 1 = every clock)
//   ADC_DATA     in   registered ADC sample
//   FLAG_FULL_N  in   FX2 full flag, 1 = endpoint has space
//   FD_OUT       out  FX2 FD data, registered
//   SLWRN        out  FX2 write strobe, active-low, registered
//   PKTENDN      out  FX2 packet commit, active-low
//   SLRDN        out  constant 1
//   SLOEN        out  constant 1
//   FIFOADR      out  constant EP_ADDR
//   OVERRUN_CNT  out  dropped-sample count, saturating
//   BUSY         out  1 whenever the FSM is not idle
//
// State table
//   IDLE   | waiting for ENABLE; counters clear on leaving
//   RUN    | sampling and writing
//   FLUSH  | sampling stopped, draining the queue
//   PKTEND | committing a short packet (FX2_PKTEND_FLUSH_EN only)

module fx2_slave_fifo_writer #(
  parameter int         DEPTH     = 16,
  parameter int         PKT_BYTES = 512,
  parameter int         DIV_W     = 26,
  parameter logic [1:0] EP_ADDR   = 2'b00
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic [DIV_W-1:0] DIV,
  input  logic [7:0]       ADC_DATA,
  input  logic             FLAG_FULL_N,
  output logic [7:0]       FD_OUT,
  output logic             SLWRN,
  output logic             PKTENDN,
  output logic             SLRDN,
  output logic             SLOEN,
  output logic [1:0]       FIFOADR,
  output logic [15:0]      OVERRUN_CNT,
  output logic             BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
`ifdef FX2_PKTEND_FLUSH_EN
  localparam logic [1:0] PKTEND = 2'd3;
`endif

  logic [1:0]       state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_max;
  logic [PW-1:0]    pkt_cnt;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [7:0]       mem [DEPTH];

  logic start, strobe, empty, full, pop, push;

  assign SLRDN   = 1'b1;
  assign SLOEN   = 1'b1;
  assign FIFOADR = EP_ADDR;
  assign BUSY    = (state != IDLE);

  assign start  = (state == IDLE) && ENABLE;
  assign div_max = (DIV <= DIV_W'(1)) ? '0 : DIV - DIV_W'(1);
  assign strobe = (state == RUN) && (div_cnt == '0);

  // Extra wrap bit separates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop  = ((state == RUN) || (state == FLUSH)) && !empty && FLAG_FULL_N;
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign push = strobe && (!full || pop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ENABLE)  state_nxt = RUN;
      RUN:   if (!ENABLE) state_nxt = FLUSH;
      FLUSH: begin
        if (empty) begin
`ifdef FX2_PKTEND_FLUSH_EN
          state_nxt = (pkt_cnt != '0) ? PKTEND : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef FX2_PKTEND_FLUSH_EN
      PKTEND: if (FLAG_FULL_N) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wrapping on >= rather than == keeps a shrinking DIV from running past it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
    end else if (start || (state != RUN)) begin
      div_cnt <= '0;
    end else if (div_cnt >= div_max) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= ADC_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FD_OUT <= '0;
      SLWRN  <= 1'b1;
    end else begin
      SLWRN <= !pop;
      if (pop) FD_OUT <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pkt_cnt <= '0;
    end else if (start) begin
      pkt_cnt <= '0;
    end else if (pop) begin
      if (pkt_cnt == PW'(PKT_BYTES - 1)) pkt_cnt <= '0;
      else                               pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OVERRUN_CNT <= '0;
    end else if (start) begin
      OVERRUN_CNT <= '0;
    end else if (strobe && full && !pop && (OVERRUN_CNT != 16'hFFFF)) begin
      OVERRUN_CNT <= OVERRUN_CNT + 16'd1;
    end
  end

`ifdef FX2_PKTEND_FLUSH_EN
  // Low for the single clock following the PKTEND edge that sees space.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PKTENDN <= 1'b1;
    end else begin
      PKTENDN <= !((state == PKTEND) && FLAG_FULL_N);
    end
  end
`else
  assign PKTENDN = 1'b1;
`endif

endmodule

// File: tb/tb_fx2_slave_fifo_writer.sv
// Directed bench for fx2_slave_fifo_writer (default parameters).
// Inputs change 1 time unit after the rising edge; writes and PKTENDN pulses
// are captured on the falling edge.

module tb_fx2_slave_fifo_writer;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ENABLE;
  logic [25:0] DIV;
  logic [7:0]  ADC_DATA;
  logic        FLAG_FULL_N;
  logic [7:0]  FD_OUT;
  logic        SLWRN;
  logic        PKTENDN;
  logic        SLRDN;
  logic        SLOEN;
  logic [1:0]  FIFOADR;
  logic [15:0] OVERRUN_CNT;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  logic [7:0] wr_q[$];
  int         wr_cyc[$];
  int         pkt_pulses = 0;
  int         cyc = 0;
  int         base;
  int         pbase;
  int         mism;

`ifdef FX2_PKTEND_FLUSH_EN
  localparam int PKT_EXP = 1;
`else
  localparam int PKT_EXP = 0;
`endif

  fx2_slave_fifo_writer dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .DIV         (DIV),
    .ADC_DATA    (ADC_DATA),
    .FLAG_FULL_N (FLAG_FULL_N),
    .FD_OUT      (FD_OUT),
    .SLWRN       (SLWRN),
    .PKTENDN     (PKTENDN),
    .SLRDN       (SLRDN),
    .SLOEN       (SLOEN),
    .FIFOADR     (FIFOADR),
    .OVERRUN_CNT (OVERRUN_CNT),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (RESET_N === 1'b1 && SLWRN === 1'b0) begin
      wr_q.push_back(FD_OUT);
      wr_cyc.push_back(cyc);
    end
    if (PKTENDN === 1'b0) pkt_pulses = pkt_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC ramps by one every clock.
  task automatic tick();
    @(posedge CLK);
    #1;
    ADC_DATA = ADC_DATA + 8'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] wr_at(input int idx);
    if (idx < wr_q.size()) return {24'd0, wr_q[idx]};
    return 32'hDEAD_BEEF;
  endfunction

  // Holds reset for two clocks, then releases with ADC_DATA=0.
  task automatic do_reset(input logic [25:0] div, input logic en, input logic flag);
    RESET_N = 1'b0;
    ticks(2);
    DIV         = div;
    ENABLE      = en;
    FLAG_FULL_N = flag;
    ADC_DATA    = 8'd0;
    base        = wr_q.size();
    pbase       = pkt_pulses;
    RESET_N     = 1'b1;
  endtask

  initial begin
    // Scenario 1: reset with ENABLE held high
    RESET_N     = 1'b1;
    ENABLE      = 1'b1;
    DIV         = 26'd4;
    FLAG_FULL_N = 1'b1;
    ADC_DATA    = 8'd0;
    #2 RESET_N = 1'b0;
    #1;
    check("rst_slwrn",   {31'd0, SLWRN},   32'd1);
    check("rst_pktendn", {31'd0, PKTENDN}, 32'd1);
    check("rst_ovr",     {16'd0, OVERRUN_CNT}, 32'd0);
    check("rst_busy",    {31'd0, BUSY},    32'd0);
    check("rst_fd",      {24'd0, FD_OUT},  32'd0);
    ticks(3);
    check("rst_hold_busy", {31'd0, BUSY}, 32'd0);
    check("const_slrdn",   {31'd0, SLRDN}, 32'd1);
    check("const_sloen",   {31'd0, SLOEN}, 32'd1);
    check("const_fifoadr", {30'd0, FIFOADR}, 32'd0);
    ADC_DATA = 8'd0;
    base     = wr_q.size();
    RESET_N  = 1'b1;
    tick();
    check("rel_busy", {31'd0, BUSY}, 32'd1);

    // Scenario 2: DIV=4 ramp, strobes at E1,E5,.. sample 1,5,9,13,17
    ticks(19);
    check("div4_count", wr_q.size() - base, 32'd5);
    for (int k = 0; k < 5; k++) check("div4_val", wr_at(base + k), 32'(1 + 4 * k));
    if (wr_cyc.size() >= base + 5)
      check("div4_spacing", wr_cyc[base + 4] - wr_cyc[base], 32'd16);
    check("div4_ovr", {16'd0, OVERRUN_CNT}, 32'd0);

    // Scenario 3: DIV=1, flag low for 40 strobes, drain 16 in order
    do_reset(26'd1, 1'b1, 1'b0);
    ticks(40);
    ENABLE = 1'b0;
    tick();
    check("ovf_ovr", {16'd0, OVERRUN_CNT}, 32'd24);
    check("ovf_no_write", wr_q.size() - base, 32'd0);
    FLAG_FULL_N = 1'b1;
    ticks(25);
    check("ovf_count", wr_q.size() - base, 32'd16);
    mism = 0;
    for (int k = 0; k < 16; k++) if (wr_at(base + k) !== 32'(k + 1)) mism++;
    check("ovf_order", mism, 32'd0);
    if (wr_cyc.size() >= base + 16)
      check("ovf_consecutive", wr_cyc[base + 15] - wr_cyc[base], 32'd15);
    check("ovf_busy", {31'd0, BUSY}, 32'd0);
    check("ovf_pktend", pkt_pulses - pbase, PKT_EXP);

    // Scenario 4/5: DIV=2, 10 samples then ENABLE=0
    do_reset(26'd2, 1'b1, 1'b1);
    ticks(20);
    ENABLE = 1'b0;
    ticks(10);
    check("short_count", wr_q.size() - base, 32'd10);
    for (int k = 0; k < 10; k++) check("short_val", wr_at(base + k), 32'(1 + 2 * k));
    check("short_pktend", pkt_pulses - pbase, PKT_EXP);
    check("short_busy", {31'd0, BUSY}, 32'd0);
    check("short_pktendn_idle", {31'd0, PKTENDN}, 32'd1);

    // Exactly one full packet: byte count wraps to 0, no commit
    do_reset(26'd2, 1'b1, 1'b1);
    ticks(1024);
    ENABLE = 1'b0;
    ticks(10);
    check("full_count", wr_q.size() - base, 32'd512);
    mism = 0;
    for (int k = 0; k < 512; k++) if (wr_at(base + k) !== 32'((1 + 2 * k) % 256)) mism++;
    check("full_order", mism, 32'd0);
    check("full_pktend", pkt_pulses - pbase, 32'd0);
    check("full_busy", {31'd0, BUSY}, 32'd0);

    // Scenario 6: reset while writing with 5 entries buffered
    do_reset(26'd1, 1'b1, 1'b0);
    ticks(6);
    FLAG_FULL_N = 1'b1;
    tick();
    check("mid_slwrn_pre", {31'd0, SLWRN}, 32'd0);
    RESET_N = 1'b0;
    #1;
    check("mid_slwrn_rst", {31'd0, SLWRN}, 32'd1);
    check("mid_busy_rst",  {31'd0, BUSY},  32'd0);
    ticks(2);
    base    = wr_q.size();
    RESET_N = 1'b1;
    ticks(2);
    check("mid_empty", wr_q.size() - base, 32'd0);
    ticks(2);
    check("mid_first_new", wr_at(base), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
